// File: rtl/output_buffer.sv
// output_buffer: elastic FIFO between the output arbiter and the downstream consumer
module output_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int SRC_WIDTH  = 3,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_in,
    output logic                  ack_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [SRC_WIDTH-1:0]  src_in,
    output logic                  req_out,
    input  logic                  ack_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [SRC_WIDTH-1:0]  src_out,
    output logic [ADDR_WIDTH:0]   count
);
    localparam int                  ENTRY_WIDTH = SRC_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] full_count  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] count_one   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ptr_one   = ADDR_WIDTH'(1);

    typedef enum logic {IDLE, ACK} state_t;

    state_t                 state, state_next;
    logic [ENTRY_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  wr_ptr, rd_ptr;
    logic                   push, pop;

    assign req_out             = (count != '0);
    assign pop                 = req_out && ack_out;
    assign {src_out, data_out} = mem[rd_ptr];

    // upstream handshake state register
    always_ff @(posedge clk) state <= !reset ? IDLE : state_next;

    // accept only from IDLE with space by registered count; ACK lasts one cycle and ignores req_in
    always_comb begin
        state_next = IDLE;
        push       = 1'b0;
        ack_in     = (state == ACK);
        if (state == IDLE && req_in && count < full_count) begin
            push       = 1'b1;
            state_next = ACK;
        end
    end

    // entry storage: source tag travels alongside its payload
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= {src_in, data_in};
        end
    end

    // pointers wrap naturally at DEPTH; occupancy tracks push/pop difference
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_one;
            if (pop) rd_ptr <= rd_ptr + ptr_one;
            if (push && !pop) count <= count + count_one;
            else if (pop && !push) count <= count - count_one;
        end
    end
endmodule
